// File: rtl/dual_port_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem_pkg
// Description : Shared types and constants for the dual-port memory block.
//               Holds the data-port FSM state enum and the wait-state bound.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_port_mem_pkg;

  // Largest number of extra data-port wait states the counter can express.
  localparam int c_WAIT_CYCLES_MAX = 15;
  localparam int c_CNT_W           = $clog2(c_WAIT_CYCLES_MAX + 1);

  // Data-port access sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dstate_t;

endpackage
`default_nettype wire

// File: rtl/dual_port_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem_if
// Description : Bus bundle for the instruction-fetch and data ports of
//               dual_port_mem. The master drives requests, the slave
//               (the memory) returns responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_port_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  import dual_port_mem_pkg::*;

  // Instruction-fetch port
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_valid;

  // Data port
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_valid;
  logic                  d_busy;
  logic                  d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  i_rdata, i_valid, d_rdata, d_valid, d_busy, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output i_rdata, i_valid, d_rdata, d_valid, d_busy, d_err
  );

endinterface
`default_nettype wire

// File: rtl/dual_port_mem_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word storage with a synchronous fetch read port (A) and a
//               synchronous byte-enabled read/write data port (B). A fetch of
//               the word being written in the same cycle returns the merged
//               new word (write-first). Out-of-range accesses read as zero
//               and never write.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import dual_port_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 128
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  // Port A: fetch read
  input  wire logic                  i_a_en,
  input  wire logic [ADDR_W-1:0]     i_a_addr,
  output logic      [DATA_W-1:0]     o_a_rdata,
  // Port B: data read/write
  input  wire logic                  i_b_en,
  input  wire logic                  i_b_we,
  input  wire logic [ADDR_W-1:0]     i_b_addr,
  input  wire logic [DATA_W-1:0]     i_b_wdata,
  input  wire logic [DATA_W/8-1:0]   i_b_be,
  output logic      [DATA_W-1:0]     o_b_rdata
);

  localparam int               c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               c_NB    = DATA_W / 8;
  localparam logic [ADDR_W:0]  c_DEPTH = (ADDR_W + 1)'(DEPTH);

  // Contents are not touched by reset; they start from the power-up zero
  // state of the storage.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;

  logic [c_IDX_W-1:0] w_a_idx;
  logic [c_IDX_W-1:0] w_b_idx;
  logic               w_a_in;
  logic               w_b_in;
  logic               w_b_wr;
  logic [DATA_W-1:0]  w_b_old;
  logic [DATA_W-1:0]  w_b_merged;

  assign w_a_idx = i_a_addr[c_IDX_W-1:0];
  assign w_b_idx = i_b_addr[c_IDX_W-1:0];
  // No modulo wrap: anything at or beyond DEPTH is simply out of range.
  assign w_a_in  = ({1'b0, i_a_addr} < c_DEPTH);
  assign w_b_in  = ({1'b0, i_b_addr} < c_DEPTH);
  assign w_b_wr  = i_b_en & i_b_we & w_b_in;
  assign w_b_old = r_mem[w_b_idx];

  // Byte-lane merge of the write data into the current word.
  for (genvar g = 0; g < c_NB; g++) begin : g_lane
    assign w_b_merged[g*8 +: 8] = i_b_be[g] ? i_b_wdata[g*8 +: 8] : w_b_old[g*8 +: 8];
  end

  // Storage update from the data port.
  always_ff @(posedge clk) begin
    if (w_b_wr) begin
      r_mem[w_b_idx] <= w_b_merged;
    end
  end

  // Fetch read register: holds when idle, bypasses a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rdata <= '0;
    end else if (i_a_en) begin
      if (!w_a_in) begin
        r_a_rdata <= '0;
      end else if (w_b_wr && (i_a_addr == i_b_addr)) begin
        r_a_rdata <= w_b_merged;
      end else begin
        r_a_rdata <= r_mem[w_a_idx];
      end
    end
  end

  // Data read register: updated on reads only, so a write leaves it held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_rdata <= '0;
    end else if (i_b_en && !i_b_we) begin
      r_b_rdata <= w_b_in ? w_b_old : '0;
    end
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/dual_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem
// Description : Memory with a single-cycle, never-stalling instruction-fetch
//               port and a sequenced data port with WAIT_CYCLES programmable
//               wait states, byte-lane writes and out-of-range error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_mem
  import dual_port_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  dual_port_mem_if.slave bus
);

  localparam int                  c_BE_W      = DATA_W / 8;
  localparam logic [ADDR_W:0]     c_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(1);

  dstate_t             r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_BE_W-1:0]   r_be;
  logic                r_d_valid;
  logic                r_d_busy;
  logic                r_d_err;
  logic                r_i_valid;

  logic                w_idle;
  logic                w_enter_resp;
  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [c_BE_W-1:0]   w_acc_be;
  logic                w_acc_oor;
  logic [DATA_W-1:0]   w_i_rdata;
  logic [DATA_W-1:0]   w_d_rdata;

  // With no wait states the access is performed on the capture edge itself,
  // so the live request fields are used while idle, the captured ones after.
  assign w_idle      = (r_state == IDLE);
  assign w_acc_we    = w_idle ? bus.d_we    : r_we;
  assign w_acc_addr  = w_idle ? bus.d_addr  : r_addr;
  assign w_acc_wdata = w_idle ? bus.d_wdata : r_wdata;
  assign w_acc_be    = w_idle ? bus.d_be    : r_be;
  assign w_acc_oor   = ({1'b0, w_acc_addr} >= c_DEPTH);

  // The edge that moves the FSM into RESP is the one that commits a write
  // and loads read data. Gated by rst_n so nothing commits while in reset.
  assign w_enter_resp = rst_n &&
                        ((w_idle && bus.d_req && (WAIT_CYCLES == 0)) ||
                         ((r_state == WAIT) && (r_cnt == c_CNT_LAST)));

  // Data-port FSM: capture, wait-state countdown, one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_d_valid <= 1'b0;
      r_d_busy  <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_d_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.d_req) begin
            r_we     <= bus.d_we;
            r_addr   <= bus.d_addr;
            r_wdata  <= bus.d_wdata;
            r_be     <= bus.d_be;
            r_d_busy <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              r_state <= WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end else begin
              r_state   <= RESP;
              r_d_valid <= 1'b1;
              r_d_err   <= w_acc_oor;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state   <= RESP;
            r_d_valid <= 1'b1;
            r_d_err   <= w_acc_oor;
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_d_busy <= 1'b0;
          r_d_err  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_d_busy <= 1'b0;
          r_d_err  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch valid follows the request by one cycle; fetch never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_valid <= 1'b0;
    end else begin
      r_i_valid <= bus.i_req;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_a_en    (bus.i_req),
    .i_a_addr  (bus.i_addr),
    .o_a_rdata (w_i_rdata),
    .i_b_en    (w_enter_resp),
    .i_b_we    (w_acc_we),
    .i_b_addr  (w_acc_addr),
    .i_b_wdata (w_acc_wdata),
    .i_b_be    (w_acc_be),
    .o_b_rdata (w_d_rdata)
  );

  assign bus.i_rdata = w_i_rdata;
  assign bus.i_valid = r_i_valid;
  assign bus.d_rdata = w_d_rdata;
  assign bus.d_valid = r_d_valid;
  assign bus.d_busy  = r_d_busy;
  assign bus.d_err   = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_mem
// Description : Scoreboard bench for dual_port_mem. The driver pushes the
//               expected fetch and data responses (from an array model of
//               the memory and cycle arithmetic) and a monitor compares them
//               against the DUT outputs as they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 128;
  localparam int W      = 2;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic        err;
  } rec_t;

  logic clk;
  logic rst_n;

  dual_port_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dual_port_mem #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = -1;
  int          acc_start = -100;
  int          acc_end = -100;
  rec_t        fq[$];
  rec_t        dq[$];

  logic [15:0] mdl [DEPTH];
  logic [15:0] mdl_last = '0;
  bit          pend_v = 1'b0;
  int          pend_commit = 0;
  int          pend_addr = 0;
  logic [15:0] pend_data = '0;
  logic [1:0]  pend_be = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc + 1, act, exp);
    end
  endtask

  // One clock of stimulus; updates the reference model and scoreboards.
  task automatic step(input bit rstv, input bit ireq, input int iaddr, input bit dreq,
                      input bit we, input int daddr, input logic [15:0] wdata,
                      input logic [1:0] be);
    rec_t r;
    @(negedge clk);
    cyc++;
    rst_n       = rstv;
    bus.i_req   = ireq;
    bus.i_addr  = 16'(iaddr);
    bus.d_req   = dreq;
    bus.d_we    = we;
    bus.d_addr  = 16'(daddr);
    bus.d_wdata = wdata;
    bus.d_be    = be;
    if (!rstv) begin
      fq.delete();
      dq.delete();
      pend_v    = 1'b0;
      acc_start = -100;
      acc_end   = -100;
      mdl_last  = '0;
    end else begin
      if (dreq && cyc > acc_end) begin
        acc_start = cyc + 1;
        acc_end   = cyc + W + 1;
        r.due     = acc_end;
        r.err     = (daddr >= DEPTH);
        if (we) begin
          r.data      = mdl_last;
          pend_v      = 1'b1;
          pend_commit = cyc + W;
          pend_addr   = daddr;
          pend_data   = wdata;
          pend_be     = be;
        end else begin
          r.data   = r.err ? 16'h0 : mdl[daddr];
          mdl_last = r.data;
        end
        dq.push_back(r);
      end
      if (pend_v && pend_commit == cyc) begin
        if (pend_addr < DEPTH) begin
          for (int b = 0; b < 2; b++)
            if (pend_be[b]) mdl[pend_addr][b*8 +: 8] = pend_data[b*8 +: 8];
        end
        pend_v = 1'b0;
      end
      if (ireq) begin
        r.due  = cyc + 1;
        r.data = (iaddr < DEPTH) ? mdl[iaddr] : 16'h0;
        r.err  = 1'b0;
        fq.push_back(r);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 16'h0, 2'b00);
  endtask

  task automatic dacc(input bit we, input int addr, input logic [15:0] wdata, input logic [1:0] be);
    step(1, 0, 0, 1, we, addr, wdata, be);
  endtask

  // Monitor: compares DUT outputs against the scoreboards each cycle.
  initial begin : monitor
    rec_t        r;
    logic [15:0] last_i;
    logic [15:0] last_d;
    bit          ev;
    last_i = '0;
    last_d = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc >= 0) begin
        if (!rst_n) begin
          chk("reset_flags", {bus.i_valid, bus.d_valid, bus.d_busy, bus.d_err}, 64'h0);
          chk("reset_rdata", {bus.i_rdata, bus.d_rdata}, 64'h0);
          last_i = '0;
          last_d = '0;
        end else begin
          ev = (fq.size() > 0) && (fq[0].due == cyc + 1);
          chk("i_valid", bus.i_valid, ev);
          if (ev) begin
            r = fq.pop_front();
            chk("i_rdata", bus.i_rdata, r.data);
            last_i = r.data;
          end else begin
            chk("i_rdata_hold", bus.i_rdata, last_i);
          end
          ev = (dq.size() > 0) && (dq[0].due == cyc + 1);
          chk("d_valid", bus.d_valid, ev);
          if (ev) begin
            r = dq.pop_front();
            chk("d_rdata", bus.d_rdata, r.data);
            chk("d_err", bus.d_err, r.err);
            last_d = r.data;
          end else begin
            chk("d_rdata_hold", bus.d_rdata, last_d);
            chk("d_err_idle", bus.d_err, 1'b0);
          end
          chk("d_busy", bus.d_busy, (cyc + 1 >= acc_start) && (cyc + 1 <= acc_end));
        end
      end
    end
  end

  initial begin : driver
    int c;
    for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
    rst_n       = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;

    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 16'h0, 2'b00);

    // Fetch from power-up contents
    step(1, 1, 5, 0, 0, 0, 16'h0, 2'b00);
    idle(1);

    // Full write, read back, partial-lane write
    dacc(1, 3, 16'hBEEF, 2'b11);  idle(4);
    dacc(0, 3, 16'h0, 2'b00);     idle(4);
    dacc(1, 3, 16'h1234, 2'b01);  idle(4);
    dacc(0, 3, 16'h0, 2'b00);     idle(4);

    // Out-of-range accesses do not alias onto addr 72
    dacc(1, 200, 16'h5A5A, 2'b11); idle(4);
    dacc(0, 200, 16'h0, 2'b00);    idle(4);
    dacc(0, 72, 16'h0, 2'b00);     idle(1);
    step(1, 1, 72, 0, 0, 0, 16'h0, 2'b00);
    idle(3);

    // Write-first fetch in the commit cycle, plus an ignored request while busy
    c = cyc + 1;
    dacc(1, 7, 16'hA5A5, 2'b11);
    step(1, 1, 7, 1, 0, 3, 16'h0, 2'b00);
    step(1, 1, 7, 0, 0, 0, 16'h0, 2'b00);
    step(1, 1, 7, 0, 0, 0, 16'h0, 2'b00);
    idle(3);
    if (cyc != c + 6) $display("note: unexpected cycle offset %0d", cyc - c);

    // Reset during wait states aborts a write to addr 9
    dacc(1, 9, 16'hFFFF, 2'b11);
    step(0, 0, 0, 0, 0, 0, 16'h0, 2'b00);
    step(0, 0, 0, 0, 0, 0, 16'h0, 2'b00);
    idle(2);
    dacc(0, 9, 16'h0, 2'b00);     idle(4);
    step(1, 1, 9, 0, 0, 0, 16'h0, 2'b00);
    // Contents survive reset
    dacc(0, 3, 16'h0, 2'b00);     idle(4);

    // Randomized traffic on both ports
    for (int k = 0; k < 600; k++) begin
      step(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
           ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 159)), 16'($urandom), 2'($urandom));
    end
    idle(8);

    chk("fetch_queue_drained", fq.size(), 0);
    chk("data_queue_drained", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
